mem_bus_arbiter: RTL and testbench

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_pkg.sv | 10 +
 rtl/mem_bus_arbiter.sv | 103 ++++++++++
 tb/tb_mem_bus_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_arbiter_pkg.sv
// mem_bus_arbiter_pkg: arbiter FSM states and the latched memory command layout
package riscv_defines;
  typedef enum logic [1:0] {IDLE, ADDR, RESP} arb_state_t;
  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_cmd_t;
endpackage

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-requester round-robin arbiter onto a single-outstanding data memory port
module mem_bus_arbiter
  import riscv_defines::*;
#(
  parameter int   TIMEOUT    = 255,
  parameter logic RESET_LAST = 1'b1
) (
  input  logic        clk,
  input  logic        start,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  output logic        m0_err,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        m1_err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_err,
  output logic        busy
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  arb_state_t state, state_n;
  mem_cmd_t cmd;
  logic owner, last_grant, pick, both, accept, finish;
  logic [CW-1:0] cnt;
  always_comb begin
    both = m0_req && m1_req;
    pick = both ? !last_grant : m1_req;
    accept = state == ADDR && mem_ready;
    finish = state == RESP && (mem_rvalid || cnt == CNT_LAST);
    state_n = state == IDLE ? ((m0_req || m1_req) ? ADDR : IDLE)
            : accept ? RESP : finish ? IDLE : state;
  end
  assign {mem_we, mem_addr, mem_wdata, mem_wstrb} = cmd;
  assign m0_gnt = start && accept && !owner;
  assign m1_gnt = start && accept && owner;
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (!start) begin
      state <= IDLE;
      owner <= 1'b0;
      last_grant <= RESET_LAST;
      cnt <= '0;
      cmd <= '0;
      mem_req <= 1'b0;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      state <= state_n;
      m0_rvalid <= 1'b0;
      m1_rvalid <= 1'b0;
      m0_err <= 1'b0;
      m1_err <= 1'b0;
      if (state == IDLE && (m0_req || m1_req)) begin
        owner <= pick;
        mem_req <= 1'b1;
        cmd <= pick ? {m1_we, m1_addr, m1_wdata, m1_wstrb} : {m0_we, m0_addr, m0_wdata, m0_wstrb};
        if (both) last_grant <= pick;
      end
      if (accept) begin
        mem_req <= 1'b0;
        cnt <= '0;
      end else if (state == RESP && cnt != CNT_MAX) begin
        cnt <= cnt + CW'(1);
      end
      // a timeout answers with err set and zero data
      if (finish && owner) begin
        m1_rvalid <= 1'b1;
        m1_err <= !mem_rvalid || mem_err;
        m1_rdata <= mem_rvalid ? mem_rdata : '0;
      end
      if (finish && !owner) begin
        m0_rvalid <= 1'b1;
        m0_err <= !mem_rvalid || mem_err;
        m0_rdata <= mem_rvalid ? mem_rdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: randomized scoreboard bench for the memory bus arbiter
module tb_mem_bus_arbiter;
  localparam int TO = 8;
  localparam logic RESET_LAST = 1'b1;
  typedef struct {
    logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;
    int rd; int rv; logic [31:0] rdata; logic err;
  } txn_t;
  typedef struct { logic port; txn_t t; } cmd_ent_t;
  typedef struct { logic port; logic [31:0] rdata; logic err; int lat; } resp_ent_t;
  logic clk, start;
  logic m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic [3:0] m0_wstrb;
  logic m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic [3:0] m1_wstrb;
  logic mem_req, mem_we, mem_ready, mem_rvalid, mem_err, busy;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0] mem_wstrb;
  int n_checks = 0, n_fail = 0, n_resp = 0, cyc = 0;
  cmd_ent_t exp_cmd[$];
  resp_ent_t exp_resp[$];
  txn_t resp_q[$];
  int acc_cyc[$];
  logic [31:0] last_rd [2];
  logic last_g = RESET_LAST;

  mem_bus_arbiter #(.TIMEOUT(TO), .RESET_LAST(RESET_LAST)) dut (
    .clk(clk), .start(start),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_err(m0_err),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_err(m1_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
    .busy(busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [79:0] act, input logic [79:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic txn_t rnd_txn();
    txn_t t;
    t.we = 1'($urandom_range(0, 1));
    t.addr = $urandom;
    t.wdata = $urandom;
    t.wstrb = 4'($urandom_range(0, 15));
    t.rd = $urandom_range(0, 5);
    t.rv = $urandom_range(0, 9);
    t.rdata = $urandom;
    t.err = ($urandom_range(0, 3) == 0);
    return t;
  endfunction

  // expected response follows from the memory's behaviour and the timeout rule alone
  function automatic void sched(input logic port, input txn_t t);
    resp_ent_t r;
    r.port = port;
    r.rdata = t.rv < TO ? t.rdata : 32'h0;
    r.err = t.rv < TO ? t.err : 1'b1;
    r.lat = t.rv < TO ? t.rv + 2 : TO + 1;
    exp_cmd.push_back('{port: port, t: t});
    resp_q.push_back(t);
    exp_resp.push_back(r);
  endfunction

  task automatic drive(input logic [1:0] who, input txn_t t0, input txn_t t1);
    if (who[0]) begin
      m0_req = 1; m0_we = t0.we; m0_addr = t0.addr; m0_wdata = t0.wdata; m0_wstrb = t0.wstrb;
    end
    if (who[1]) begin
      m1_req = 1; m1_we = t1.we; m1_addr = t1.addr; m1_wdata = t1.wdata; m1_wstrb = t1.wstrb;
    end
  endtask

  task automatic finish_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  endtask

  task automatic run(input logic [1:0] who, input txn_t t0, input txn_t t1);
    logic first, d0, d1;
    int target, i;
    first = (who == 2'b11) ? !last_g : who[1];
    sched(first, first ? t1 : t0);
    if (who == 2'b11) begin
      sched(!first, first ? t0 : t1);
      last_g = first;
    end
    target = n_resp + ((who == 2'b11) ? 2 : 1);
    @(posedge clk); #1;
    drive(who, t0, t1);
    i = 0;
    while (n_resp < target && i < 60) begin
      @(negedge clk);
      if (i == 1) chk("req_to_mem_req", mem_req, 1);
      d0 = m0_gnt;
      d1 = m1_gnt;
      @(posedge clk); #1;
      if (d0) m0_req = 0;
      if (d1) m1_req = 0;
      i++;
    end
    if (n_resp < target) begin
      chk("resp_wait_expired", n_resp, target);
      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
      $fatal(1, "response wait expired");
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [1:0] ph;
    int w;
    txn_t p;
    mem_ready = 0; mem_rvalid = 0; mem_rdata = 0; mem_err = 0; ph = 0; w = 0;
    forever begin
      @(posedge clk); #1;
      mem_ready = 0; mem_rvalid = 0; mem_err = 0; mem_rdata = $urandom;
      if (ph == 0 && start && mem_req && resp_q.size() > 0) begin
        p = resp_q.pop_front();
        w = p.rd;
        ph = 1;
      end
      if (ph == 1) begin
        if (w == 0) begin
          mem_ready = 1;
          mem_rvalid = 1'($urandom_range(0, 1));
          mem_err = 1'($urandom_range(0, 1));
          w = p.rv;
          ph = 2;
        end else w--;
      end else if (ph == 2) begin
        if (w == 0) begin
          mem_rvalid = 1; mem_rdata = p.rdata; mem_err = p.err; ph = 0;
        end else w--;
      end
    end
  end

  always @(negedge clk) begin
    cmd_ent_t e;
    resp_ent_t r;
    logic acc, g0, g1;
    if (start !== 1'b1) begin
      last_rd[0] = 0;
      last_rd[1] = 0;
      acc_cyc.delete();
    end else begin
      acc = mem_req && mem_ready;
      g0 = 0;
      g1 = 0;
      if (mem_req) begin
        if (exp_cmd.size() == 0) chk("spurious_mem_req", mem_req, 0);
        else begin
          e = exp_cmd[0];
          chk("mem_cmd", {mem_we, mem_addr, mem_wdata, mem_wstrb}, {e.t.we, e.t.addr, e.t.wdata, e.t.wstrb});
          chk("busy_addr", busy, 1);
          g0 = acc && !e.port;
          g1 = acc && e.port;
          if (acc) begin
            void'(exp_cmd.pop_front());
            acc_cyc.push_back(cyc);
          end
        end
      end
      chk("gnt", {m0_gnt, m1_gnt}, {g0, g1});
      if (m0_rvalid || m1_rvalid) begin
        if (exp_resp.size() == 0) chk("spurious_rvalid", {m0_rvalid, m1_rvalid}, 0);
        else begin
          r = exp_resp.pop_front();
          chk("rvalid_port", {m0_rvalid, m1_rvalid}, {!r.port, r.port});
          chk("rdata", r.port ? m1_rdata : m0_rdata, r.rdata);
          chk("err", {m0_err, m1_err}, {!r.port && r.err, r.port && r.err});
          chk("other_rdata_hold", r.port ? m0_rdata : m1_rdata, last_rd[!r.port]);
          chk("latency", acc_cyc.size() > 0 ? cyc - acc_cyc.pop_front() : -1, r.lat);
          chk("busy_at_rvalid", busy, 0);
          last_rd[r.port] = r.rdata;
          n_resp++;
        end
      end else chk("err_quiet", {m0_err, m1_err}, 0);
    end
  end

  initial begin
    txn_t t0, t1;
    int i, n0;
    logic seen;
    start = 0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ctrl", {mem_req, busy, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err}, 0);
    chk("rst_cmd", {mem_we, mem_addr, mem_wdata, mem_wstrb}, 0);
    chk("rst_rdata", {m0_rdata, m1_rdata}, 0);
    @(posedge clk); #1;
    start = 1;
    t0 = rnd_txn(); t1 = rnd_txn();
    t0.we = 0; t0.addr = 32'h100; t0.rd = 0; t0.rv = 0; t0.rdata = 32'hDEADBEEF; t0.err = 0;
    run(2'b01, t0, t1);
    run(2'b11, rnd_txn(), rnd_txn());
    run(2'b11, rnd_txn(), rnd_txn());
    t0 = rnd_txn(); t0.rd = 5; t0.rv = 1;
    run(2'b01, t0, t1);
    t1 = rnd_txn(); t1.rv = 9;
    run(2'b10, t0, t1);
    t0 = rnd_txn(); t0.rv = 8;
    run(2'b01, t0, t1);
    t1 = rnd_txn(); t1.we = 1; t1.wstrb = 4'hF; t1.err = 1; t1.rv = 2;
    run(2'b10, t0, t1);
    for (int s = 0; s < 60; s++) run(2'($urandom_range(1, 3)), rnd_txn(), rnd_txn());
    t0 = rnd_txn(); t0.rd = 0; t0.rv = 3;
    exp_cmd.push_back('{port: 1'b0, t: t0});
    resp_q.push_back(t0);
    @(posedge clk); #1;
    drive(2'b01, t0, t1);
    i = 0;
    seen = 0;
    while (!seen && i < 20) begin
      @(negedge clk);
      seen = mem_req && mem_ready;
      i++;
    end
    chk("reset_test_accept", seen, 1);
    @(posedge clk); #1;
    m0_req = 0;
    start = 0;
    @(posedge clk); #1;
    start = 1;
    last_g = RESET_LAST;
    @(negedge clk);
    chk("busy_after_reset", busy, 0);
    chk("rdata_after_reset", {m0_rdata, m1_rdata}, 0);
    n0 = n_resp;
    repeat (10) @(negedge clk);
    chk("no_rvalid_after_reset", n_resp, n0);
    @(posedge clk); #1;
    run(2'b11, rnd_txn(), rnd_txn());
    finish_run();
  end
endmodule
